// File: rtl/polar_to_cartesian_pipe.sv
// Two-stage handshaked polar-to-cartesian converter: x = r*cos(15k), y = r*sin(15k).
// Stage 1 decodes the angle index into sine-table indices and signs; stage 2 scales and signs.
module polar_to_cartesian_pipe #(
  parameter int unsigned R_WIDTH     = 8,
  parameter int unsigned THETA_WIDTH = 4,
  parameter bit          FULL_CIRCLE = 1'b0,
  parameter bit          ROUND       = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [R_WIDTH-1:0]        in_r,
  input  logic [THETA_WIDTH-1:0]    in_theta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [R_WIDTH:0]   out_x,
  output logic signed [R_WIDTH:0]   out_y,
  output logic                      out_err
);

  localparam int unsigned PW   = R_WIDTH + 9;
  localparam int unsigned KMax = FULL_CIRCLE ? 23 : 12;

  // round(256*sin(15i deg)), 8 fractional bits
  function automatic logic [8:0] sin_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    sin_lut = 9'd0;
      3'd1:    sin_lut = 9'd66;
      3'd2:    sin_lut = 9'd128;
      3'd3:    sin_lut = 9'd181;
      3'd4:    sin_lut = 9'd222;
      3'd5:    sin_lut = 9'd247;
      3'd6:    sin_lut = 9'd256;
      default: sin_lut = 9'd0;
    endcase
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 decode
  int unsigned k;
  logic [2:0]  dec_xi, dec_yi;
  logic        dec_xneg, dec_yneg, dec_err;

  always_comb begin
    k        = 32'(in_theta);
    dec_xi   = 3'd0;
    dec_yi   = 3'd0;
    dec_xneg = 1'b0;
    dec_yneg = 1'b0;
    dec_err  = 1'b0;
    // Out-of-range angles select S[0]=0 with positive signs, so stage 2 emits +0 naturally.
    if (k > KMax) begin
      dec_err = 1'b1;
    end else if (k <= 6) begin
      dec_xi = 3'(6 - k);
      dec_yi = 3'(k);
    end else if (k <= 12) begin
      dec_xi   = 3'(k - 6);
      dec_yi   = 3'(12 - k);
      dec_xneg = 1'b1;
    end else if (k <= 18) begin
      dec_xi   = 3'(18 - k);
      dec_yi   = 3'(k - 12);
      dec_xneg = 1'b1;
      dec_yneg = 1'b1;
    end else begin
      dec_xi   = 3'(k - 18);
      dec_yi   = 3'(24 - k);
      dec_yneg = 1'b1;
    end
  end

  logic               s1_valid;
  logic [R_WIDTH-1:0] s1_r;
  logic [2:0]         s1_xi, s1_yi;
  logic               s1_xneg, s1_yneg, s1_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_xi    <= 3'd0;
      s1_yi    <= 3'd0;
      s1_xneg  <= 1'b0;
      s1_yneg  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_r    <= in_r;
        s1_xi   <= dec_xi;
        s1_yi   <= dec_yi;
        s1_xneg <= dec_xneg;
        s1_yneg <= dec_yneg;
        s1_err  <= dec_err;
      end
    end
  end

  // Stage 2 scale, round and sign
  logic [PW-1:0]         prod_x, prod_y;
  logic [R_WIDTH:0]      mag_x, mag_y;
  logic signed [R_WIDTH:0] res_x, res_y;

  always_comb begin
    prod_x = PW'(s1_r) * PW'(sin_lut(s1_xi)) + PW'(ROUND ? 128 : 0);
    prod_y = PW'(s1_r) * PW'(sin_lut(s1_yi)) + PW'(ROUND ? 128 : 0);
    // Magnitude never exceeds r, so the top bit of mag is always clear.
    mag_x  = (R_WIDTH + 1)'(prod_x >> 8);
    mag_y  = (R_WIDTH + 1)'(prod_y >> 8);
    res_x  = s1_xneg ? -mag_x : mag_x;
    res_y  = s1_yneg ? -mag_y : mag_y;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x   <= res_x;
        out_y   <= res_y;
        out_err <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_polar_to_cartesian_pipe.sv
// Scoreboard bench: two converter configurations share one stimulus stream;
// expected results are queued on input acceptance and compared on output transfer.
module tb_polar_to_cartesian_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_r      = 8'd0;
  logic [4:0] in_theta  = 5'd0;
  logic       in_ready_a, in_ready_b, out_valid_a, out_valid_b, err_a, err_b;
  logic signed [8:0] xa, ya, xb, yb;

  // a: full circle, truncate
  polar_to_cartesian_pipe #(
    .R_WIDTH(8), .THETA_WIDTH(5), .FULL_CIRCLE(1'b1), .ROUND(1'b0)
  ) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_r(in_r), .in_theta(in_theta), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_x(xa), .out_y(ya), .out_err(err_a)
  );

  // b: half plane, round
  polar_to_cartesian_pipe #(
    .R_WIDTH(8), .THETA_WIDTH(4), .FULL_CIRCLE(1'b0), .ROUND(1'b1)
  ) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_r(in_r), .in_theta(in_theta[3:0]), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_x(xb), .out_y(yb), .out_err(err_b)
  );

  typedef struct {
    int x;
    int y;
    int err;
    bit lat;
    int acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   took = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   ov_a = 1'b0, ov_b = 1'b0, cur_lat = 1'b0;
  exp_t ea_ov, eb_ov;
  bit   prev_stall = 1'b0;
  int   px_a, py_a, pe_a, px_b, py_b;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int err);
    exp_t e;
    e.x = x; e.y = y; e.err = err; e.lat = 1'b0; e.acc = 0;
    return e;
  endfunction

  // r*sin(15k deg) using a folded sine table
  function automatic int trig(input int r, input int kk, input bit rnd);
    int tbl[7] = '{0, 66, 128, 181, 222, 247, 256};
    int i;
    int m;
    i = kk % 12;
    if (i > 6) i = 12 - i;
    m = (r * tbl[i] + (rnd ? 128 : 0)) / 256;
    return (kk > 12) ? -m : m;
  endfunction

  function automatic exp_t model(input int r, input int kk, input bit fc, input bit rnd);
    if (kk > (fc ? 23 : 12)) return mk(0, 0, 1);
    return mk(trig(r, (kk + 6) % 24, rnd), trig(r, kk, rnd), 0);
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (rnd_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      took = in_valid && in_ready_a;
      if (prev_stall) begin
        check_eq("hold_valid", int'(out_valid_a), 1);
        check_eq("hold_x_a", int'(xa), px_a);
        check_eq("hold_y_a", int'(ya), py_a);
        check_eq("hold_err_a", int'(err_a), pe_a);
        check_eq("hold_x_b", int'(xb), px_b);
        check_eq("hold_y_b", int'(yb), py_b);
      end
      if (out_valid_a && !out_ready) check_eq("stall_in_ready", int'(in_ready_a), 0);
      prev_stall = out_valid_a && !out_ready;
      px_a = int'(xa); py_a = int'(ya); pe_a = int'(err_a); px_b = int'(xb); py_b = int'(yb);

      if (out_valid_a && out_ready) begin
        check_eq("a_expected_out", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check_eq("a_x", int'(xa), e.x);
          check_eq("a_y", int'(ya), e.y);
          check_eq("a_err", int'(err_a), e.err);
          if (e.lat) check_eq("a_latency", cyc + 1 - e.acc, 2);
        end
      end
      if (out_valid_b && out_ready) begin
        check_eq("b_expected_out", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check_eq("b_x", int'(xb), e.x);
          check_eq("b_y", int'(yb), e.y);
          check_eq("b_err", int'(err_b), e.err);
        end
      end

      if (in_valid && in_ready_a) begin
        e = ov_a ? ea_ov : model(int'(in_r), int'(in_theta), 1'b1, 1'b0);
        e.lat = cur_lat;
        e.acc = cyc + 1;
        qa.push_back(e);
      end
      if (in_valid && in_ready_b) begin
        e = ov_b ? eb_ov : model(int'(in_r), int'(in_theta[3:0]), 1'b0, 1'b1);
        qb.push_back(e);
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int r, input int kk, input bit lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_r     = 8'(r);
    in_theta = 5'(kk);
    cur_lat  = lat;
    do begin
      @(posedge clock);
      n++;
    end while (!took && n < 200);
    if (n >= 200) check_eq("send_timeout", int'(took), 1);
    #1;
    in_valid = 1'b0;
    ov_a     = 1'b0;
    ov_b     = 1'b0;
    cur_lat  = 1'b0;
  endtask

  task automatic sendx(input int r, input int kk, input bit oa, input exp_t a,
                       input bit ob, input exp_t b, input bit lat);
    ov_a  = oa;
    ea_ov = a;
    ov_b  = ob;
    eb_ov = b;
    send(r, kk, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() + qb.size()) > 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    if (n >= 100) check_eq("drain", int'(qa.size() + qb.size()), 0);
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = mk(0, 0, 0);
    #12;
    check_eq("rst_valid", int'(out_valid_a), 0);
    check_eq("rst_x", int'(xa), 0);
    check_eq("rst_y", int'(ya), 0);
    check_eq("rst_err", int'(err_a), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", int'(in_ready_a), 1);
    sync();

    sendx(200, 2, 1'b1, mk(173, 100, 0), 1'b1, mk(173, 100, 0), 1'b1);
    drain();
    sendx(100, 9, 1'b1, mk(-70, 70, 0), 1'b1, mk(-71, 71, 0), 1'b1);
    drain();

    sendx(255, 18, 1'b1, mk(0, -255, 0), 1'b0, z, 1'b0);
    sendx(255, 24, 1'b1, mk(0, 0, 1), 1'b0, z, 1'b0);
    sendx(255, 0, 1'b1, mk(255, 0, 0), 1'b0, z, 1'b0);
    sendx(50, 13, 1'b0, z, 1'b1, mk(0, 0, 1), 1'b0);
    sendx(0, 5, 1'b1, mk(0, 0, 0), 1'b1, mk(0, 0, 0), 1'b0);
    sendx(255, 6, 1'b1, mk(0, 255, 0), 1'b1, mk(0, 255, 0), 1'b0);
    sendx(77, 12, 1'b1, mk(-77, 0, 0), 1'b1, mk(-77, 0, 0), 1'b0);
    drain();

    fork
      begin
        for (int kk = 0; kk <= 12; kk++) begin
          if (kk == 4) sendx(128, 4, 1'b1, mk(64, 111, 0), 1'b1, mk(64, 111, 0), 1'b0);
          else send(128, kk, 1'b0);
        end
      end
      begin
        repeat (6) @(posedge clock);
        #2;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two samples in flight
    send(10, 1, 1'b0);
    send(20, 2, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid_a", int'(out_valid_a), 0);
    check_eq("midrst_valid_b", int'(out_valid_b), 0);
    check_eq("midrst_x", int'(xa), 0);
    check_eq("midrst_y", int'(ya), 0);
    check_eq("midrst_err", int'(err_a), 0);
    qa.delete();
    qb.delete();
    @(negedge clock);
    reset = 1'b0;
    sync();
    sync();
    check_eq("postrst_idle", int'(out_valid_a), 0);
    send(30, 3, 1'b1);
    drain();
    repeat (4) sync();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) sync();
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 1'b0);
    end
    rnd_rdy = 1'b0;
    sync();
    out_ready = 1'b1;
    drain();
    repeat (3) sync();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
